spi_link_sched: RTL and testbench
=================================

Name: spi_link_sched

Overview:
- Command and telemetry scheduler that sits between the SPI slave link and the pan/tilt motor driver, beside the vision tracker.
- Receives decoded MOSI frames, validates them, deduplicates them, and issues motor commands over a valid/ready handshake through a one-deep skid buffer.
- Runs a link watchdog that drives the motors to home when frames stop arriving.
- Snapshots tracker coordinates and status so every MISO frame is coherent.

Parameters:
- TIMEOUT_CYC, 5_000_000, clk cycles without a good frame before SAFE (50 ms at 100 MHz).
- HOME_X, 8'd128, x command issued on timeout.
- HOME_Y, 7'd64, y command issued on timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cs_sync  in  1  synchronized SPI chip select, active-low
- rx_valid  in  1  one-cycle pulse; a MOSI frame has completed
- rx_xdata  in  8  frame[31:24]
- rx_ydata  in  7  frame[23:17]
- rx_etc  in  17  frame[16:0]: [16:13] seq, [12:11] cmd, [10:8] reserved, [7:0] checksum
- det_valid  in  1  tracker result strobe
- det_x  in  10  tracker x
- det_y  in  9  tracker y
- enemy_xdata  out  10  x to MISO packer
- enemy_ydata  out  9  y to MISO packer
- miso_etc  out  13  status to MISO packer
- cmd_valid  out  1  motor command valid
- cmd_ready  in  1  motor driver accepts
- cmd_x  out  8  motor x
- cmd_y  out  7  motor y
- cmd_type  out  2  00 NOP, 01 MOVE, 10 HOME, 11 HOLD
- link_ok  out  1  a good frame was received within TIMEOUT_CYC

Behaviour:
- Reset (reset=0, asynchronous): state LINK_DOWN; all outputs 0; seq_last=4'hF; err_cnt=0; skid buffer empty; watchdog=0.
- Checksum: good when rx_etc[7:0] == rx_xdata ^ {1'b0,rx_ydata} ^ rx_etc[16:9]. Evaluated on the rx_valid cycle only.
- Bad checksum: frame dropped; err_cnt += 1, saturating at 15; watchdog not refreshed.
- Good frame, seq == seq_last: duplicate; watchdog cleared; no command.
- Good frame, cmd == NOP: seq_last updated; watchdog cleared; no command.
- Good frame, other cmd: seq_last updated; watchdog cleared; command enqueued.
- Enqueue path: if output slot empty, load the output registers; cmd_valid rises the next cycle. Otherwise load the skid buffer.
- Skid buffer full on enqueue: overwrite it (latest wins); sticky overrun=1 until reset.
- Handshake: cmd_x/cmd_y/cmd_type stable while cmd_valid=1. The transfer happens on a cycle with cmd_valid & cmd_ready. On the next cycle:
  - skid buffer full: the output slot takes the buffer; cmd_valid stays 1.
  - skid buffer empty: cmd_valid=0.
- Simultaneous transfer and enqueue on the same cycle: the buffered entry (if any) moves to output and the new frame enters the buffer. If the buffer was empty, the new frame goes straight to output. No frame is lost and ordering is preserved.
- Watchdog: increments each cycle, saturating at TIMEOUT_CYC. Any good frame clears it.
- States (encoding 00 LINK_DOWN, 01 UP, 10 SAFE_ISSUE, 11 SAFE):
  - LINK_DOWN -> UP on the first good frame.
  - UP -> SAFE_ISSUE when watchdog reaches TIMEOUT_CYC. On entry, flush the skid buffer and force the output slot to HOME_X/HOME_Y/HOME with cmd_valid=1. A command currently pending is replaced, since safety wins.
  - SAFE_ISSUE -> SAFE on the HOME transfer.
  - SAFE_ISSUE or SAFE -> UP on the next good non-duplicate frame, processed normally. In SAFE_ISSUE that frame is buffered behind HOME.
- link_ok = 1 in state UP only.
- Coherent snapshot:
  - det_valid captures det_x/det_y into shadow registers and sets det_fresh.
  - enemy_xdata/enemy_ydata load from the shadows only on cycles where cs_sync=1, so they are frozen during a transfer.
  - det_fresh clears on rx_valid. If det_valid and rx_valid coincide, det_fresh=1.
- miso_etc = {seq_last[3:0], det_fresh, link_ok, cmd_valid, err_cnt[3:0], state[1:0]}, registered, updated only while cs_sync=1.
- Latency: rx_valid at cycle N gives cmd_valid=1 at N+1 when the slot is free.

Test Plan:
- Reset release, then a good frame x=0x40, y=0x20, seq=1, cmd=MOVE, cmd_ready=1 -> cmd_valid=1 one cycle after rx_valid; cmd_x=0x40, cmd_y=0x20, cmd_type=01; link_ok=1; miso_etc[12:9]=1.
- Same frame with checksum bit 0 flipped -> no cmd_valid; err_cnt=1. Send 20 bad frames -> err_cnt stays 15.
- cmd_ready=0; send seq 2, 3, 4 (MOVE) -> output holds seq 2; buffer holds 4; overrun=1. Raise cmd_ready -> transfers seq 2 then 4, back-to-back.
- Repeat seq 5 twice -> exactly one command issued; watchdog cleared by both frames.
- TIMEOUT_CYC=100; no frames for 100 cycles -> state SAFE_ISSUE; cmd=HOME, 128, 64; link_ok=0. After transfer -> SAFE. Good frame seq 6 -> UP.
- Hold cs_sync=0; pulse det_valid with det_x=300 -> enemy_xdata unchanged until cs_sync=1, then 300. Assert reset=0 mid-ISSUE -> cmd_valid=0 immediately.

Source files
------------

// File: rtl/spi_link_sched.sv
// Command/telemetry scheduler between the SPI slave link and the pan/tilt motor driver.
// Validates and deduplicates MOSI frames, queues motor commands, and runs a link watchdog.
module spi_link_sched #(
   parameter int unsigned TIMEOUT_CYC = 5_000_000,
   parameter logic [7:0]  HOME_X      = 8'd128,
   parameter logic [6:0]  HOME_Y      = 7'd64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs_sync,
   input  logic        rx_valid,
   input  logic [7:0]  rx_xdata,
   input  logic [6:0]  rx_ydata,
   input  logic [16:0] rx_etc,
   input  logic        det_valid,
   input  logic [9:0]  det_x,
   input  logic [8:0]  det_y,
   output logic [9:0]  enemy_xdata,
   output logic [8:0]  enemy_ydata,
   output logic [12:0] miso_etc,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [7:0]  cmd_x,
   output logic [6:0]  cmd_y,
   output logic [1:0]  cmd_type,
   output logic        link_ok
);

   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);
   localparam logic [1:0] CMD_NOP  = 2'b00;
   localparam logic [1:0] CMD_HOME = 2'b10;

   typedef enum logic [1:0] {
      LINK_DOWN  = 2'b00,
      UP         = 2'b01,
      SAFE_ISSUE = 2'b10,
      SAFE       = 2'b11
   } state_t;

   state_t          r_state;
   logic            r_link_ok;
   logic [WD_W-1:0] r_wdog;
   logic [3:0]      r_seq_last;
   logic [3:0]      r_err_cnt;
   logic            r_overrun;

   logic            r_cmd_valid;
   logic [7:0]      r_cmd_x;
   logic [6:0]      r_cmd_y;
   logic [1:0]      r_cmd_type;
   logic            r_skid_full;
   logic [7:0]      r_skid_x;
   logic [6:0]      r_skid_y;
   logic [1:0]      r_skid_type;

   logic [9:0]      r_shadow_x;
   logic [8:0]      r_shadow_y;
   logic            r_det_fresh;
   logic [9:0]      r_enemy_x;
   logic [8:0]      r_enemy_y;
   logic [12:0]     r_miso_etc;

   logic [3:0]      w_seq;
   logic [1:0]      w_cmd;
   logic            w_chk_ok;
   logic            w_good;
   logic            w_bad;
   logic            w_new;
   logic            w_enq;
   logic            w_xfer;
   logic            w_to_safe;
   logic            w_unused;

   assign w_seq     = rx_etc[16:13];
   assign w_cmd     = rx_etc[12:11];
   assign w_chk_ok  = (rx_etc[7:0] == (rx_xdata ^ {1'b0, rx_ydata} ^ rx_etc[16:9]));
   assign w_good    = rx_valid & w_chk_ok;
   assign w_bad     = rx_valid & ~w_chk_ok;
   assign w_new     = w_good & (w_seq != r_seq_last);
   assign w_enq     = w_new & (w_cmd != CMD_NOP);
   assign w_xfer    = r_cmd_valid & cmd_ready;
   assign w_to_safe = (r_state == UP) & ~w_good & (r_wdog == WD_MAX);

   // Overrun is a sticky debug flag with no port of its own; reserved bit 8 carries no meaning.
   assign w_unused  = ^{rx_etc[8], r_overrun};

   // Link state, watchdog, sequence tracking and error counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= LINK_DOWN;
         r_link_ok  <= 1'b0;
         r_wdog     <= '0;
         r_seq_last <= 4'hF;
         r_err_cnt  <= 4'd0;
      end else begin
         if (w_good)
            r_wdog <= '0;
         else if (r_wdog != WD_MAX)
            r_wdog <= r_wdog + WD_W'(1);

         if (w_new)
            r_seq_last <= w_seq;

         if (w_bad && (r_err_cnt != 4'hF))
            r_err_cnt <= r_err_cnt + 4'd1;

         case (r_state)
            LINK_DOWN: begin
               if (w_good) begin
                  r_state   <= UP;
                  r_link_ok <= 1'b1;
               end
            end
            UP: begin
               if (w_to_safe) begin
                  r_state   <= SAFE_ISSUE;
                  r_link_ok <= 1'b0;
               end
            end
            SAFE_ISSUE: begin
               if (w_new) begin
                  r_state   <= UP;
                  r_link_ok <= 1'b1;
               end else if (w_xfer) begin
                  r_state   <= SAFE;
               end
            end
            SAFE: begin
               if (w_new) begin
                  r_state   <= UP;
                  r_link_ok <= 1'b1;
               end
            end
            default: begin
               r_state   <= LINK_DOWN;
               r_link_ok <= 1'b0;
            end
         endcase
      end
   end

   // Output slot plus one-deep skid buffer; the skid entry always precedes any new frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cmd_valid <= 1'b0;
         r_cmd_x     <= 8'd0;
         r_cmd_y     <= 7'd0;
         r_cmd_type  <= 2'b00;
         r_skid_full <= 1'b0;
         r_skid_x    <= 8'd0;
         r_skid_y    <= 7'd0;
         r_skid_type <= 2'b00;
         r_overrun   <= 1'b0;
      end else if (w_to_safe) begin
         r_cmd_valid <= 1'b1;
         r_cmd_x     <= HOME_X;
         r_cmd_y     <= HOME_Y;
         r_cmd_type  <= CMD_HOME;
         r_skid_full <= 1'b0;
      end else if (w_xfer) begin
         if (r_skid_full) begin
            r_cmd_x    <= r_skid_x;
            r_cmd_y    <= r_skid_y;
            r_cmd_type <= r_skid_type;
            if (w_enq) begin
               r_skid_x    <= rx_xdata;
               r_skid_y    <= rx_ydata;
               r_skid_type <= w_cmd;
            end else begin
               r_skid_full <= 1'b0;
            end
         end else if (w_enq) begin
            r_cmd_x    <= rx_xdata;
            r_cmd_y    <= rx_ydata;
            r_cmd_type <= w_cmd;
         end else begin
            r_cmd_valid <= 1'b0;
         end
      end else if (w_enq) begin
         if (!r_cmd_valid) begin
            r_cmd_valid <= 1'b1;
            r_cmd_x     <= rx_xdata;
            r_cmd_y     <= rx_ydata;
            r_cmd_type  <= w_cmd;
         end else begin
            if (r_skid_full)
               r_overrun <= 1'b1;
            r_skid_full <= 1'b1;
            r_skid_x    <= rx_xdata;
            r_skid_y    <= rx_ydata;
            r_skid_type <= w_cmd;
         end
      end
   end

   // Tracker shadows and MISO-side registers, frozen while chip select is asserted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shadow_x  <= 10'd0;
         r_shadow_y  <= 9'd0;
         r_det_fresh <= 1'b0;
         r_enemy_x   <= 10'd0;
         r_enemy_y   <= 9'd0;
         r_miso_etc  <= 13'd0;
      end else begin
         if (det_valid) begin
            r_shadow_x  <= det_x;
            r_shadow_y  <= det_y;
            r_det_fresh <= 1'b1;
         end else if (rx_valid) begin
            r_det_fresh <= 1'b0;
         end

         if (cs_sync) begin
            r_enemy_x  <= r_shadow_x;
            r_enemy_y  <= r_shadow_y;
            r_miso_etc <= {r_seq_last, r_det_fresh, r_link_ok, r_cmd_valid, r_err_cnt, r_state};
         end
      end
   end

   assign enemy_xdata = r_enemy_x;
   assign enemy_ydata = r_enemy_y;
   assign miso_etc    = r_miso_etc;
   assign cmd_valid   = r_cmd_valid;
   assign cmd_x       = r_cmd_x;
   assign cmd_y       = r_cmd_y;
   assign cmd_type    = r_cmd_type;
   assign link_ok     = r_link_ok;

endmodule

// File: tb/tb_spi_link_sched.sv
// Directed self-checking bench for spi_link_sched with a 100-cycle link timeout.
module tb_spi_link_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs_sync;
   logic        rx_valid;
   logic [7:0]  rx_xdata;
   logic [6:0]  rx_ydata;
   logic [16:0] rx_etc;
   logic        det_valid;
   logic [9:0]  det_x;
   logic [8:0]  det_y;
   logic [9:0]  enemy_xdata;
   logic [8:0]  enemy_ydata;
   logic [12:0] miso_etc;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_x;
   logic [6:0]  cmd_y;
   logic [1:0]  cmd_type;
   logic        link_ok;

   int n_chk  = 0;
   int n_pass = 0;
   int n_xfer = 0;

   localparam logic [1:0] NOP  = 2'b00;
   localparam logic [1:0] MOVE = 2'b01;
   localparam logic [1:0] HOME = 2'b10;

   spi_link_sched #(.TIMEOUT_CYC(100)) dut (
      .clk(clk), .reset(reset), .cs_sync(cs_sync),
      .rx_valid(rx_valid), .rx_xdata(rx_xdata), .rx_ydata(rx_ydata), .rx_etc(rx_etc),
      .det_valid(det_valid), .det_x(det_x), .det_y(det_y),
      .enemy_xdata(enemy_xdata), .enemy_ydata(enemy_ydata), .miso_etc(miso_etc),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
      .cmd_type(cmd_type), .link_ok(link_ok)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (reset && cmd_valid && cmd_ready) n_xfer <= n_xfer + 1;

   // One frame: rx_valid for exactly one cycle; returns on the negedge after it is processed.
   task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [3:0] seq,
                       input logic [1:0] cmd, input logic bad);
      logic [7:0] chk;
      chk = x ^ {1'b0, y} ^ {seq, cmd, 2'b00};
      if (bad) chk = chk ^ 8'h01;
      @(negedge clk);
      rx_xdata = x;
      rx_ydata = y;
      rx_etc   = {seq, cmd, 3'b000, chk};
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0; cs_sync = 1'b1; cmd_ready = 1'b1; rx_valid = 1'b0;
      rx_xdata = '0; rx_ydata = '0; rx_etc = '0; det_valid = 1'b0; det_x = '0; det_y = '0;
      repeat (3) @(negedge clk);
      n_chk++; if (cmd_valid !== 1'b0) $display("FAIL rst_cmd_valid: got %0h want 0", cmd_valid); else n_pass++;
      n_chk++; if (link_ok !== 1'b0) $display("FAIL rst_link_ok: got %0h want 0", link_ok); else n_pass++;
      n_chk++; if (miso_etc !== 13'h0) $display("FAIL rst_miso: got %0h want 0", miso_etc); else n_pass++;
      n_chk++; if (enemy_xdata !== 10'h0) $display("FAIL rst_enemy_x: got %0h want 0", enemy_xdata); else n_pass++;
      n_chk++; if (cmd_type !== 2'b00) $display("FAIL rst_cmd_type: got %0h want 0", cmd_type); else n_pass++;
      reset = 1'b1;
      @(negedge clk);
      n_chk++; if (miso_etc !== 13'h1E00) $display("FAIL rst_miso_seq: got %0h want 1e00", miso_etc); else n_pass++;
   endtask

   task automatic test_move;
      send(8'h40, 7'h20, 4'd1, MOVE, 1'b0);
      n_chk++; if (cmd_valid !== 1'b1) $display("FAIL move_valid: got %0h want 1", cmd_valid); else n_pass++;
      n_chk++; if (cmd_x !== 8'h40) $display("FAIL move_x: got %0h want 40", cmd_x); else n_pass++;
      n_chk++; if (cmd_y !== 7'h20) $display("FAIL move_y: got %0h want 20", cmd_y); else n_pass++;
      n_chk++; if (cmd_type !== MOVE) $display("FAIL move_type: got %0h want 1", cmd_type); else n_pass++;
      n_chk++; if (link_ok !== 1'b1) $display("FAIL move_link_ok: got %0h want 1", link_ok); else n_pass++;
      @(negedge clk);
      n_chk++; if (cmd_valid !== 1'b0) $display("FAIL move_done: got %0h want 0", cmd_valid); else n_pass++;
      n_chk++; if (miso_etc[12:9] !== 4'd1) $display("FAIL move_miso_seq: got %0h want 1", miso_etc[12:9]); else n_pass++;
      n_chk++; if (miso_etc[1:0] !== 2'b01) $display("FAIL move_miso_state: got %0h want 1", miso_etc[1:0]); else n_pass++;
   endtask

   task automatic test_bad_checksum;
      send(8'h40, 7'h20, 4'd1, MOVE, 1'b1);
      n_chk++; if (cmd_valid !== 1'b0) $display("FAIL bad_no_cmd: got %0h want 0", cmd_valid); else n_pass++;
      @(negedge clk);
      n_chk++; if (miso_etc[5:2] !== 4'd1) $display("FAIL bad_err1: got %0h want 1", miso_etc[5:2]); else n_pass++;
      for (int i = 0; i < 20; i++) send(8'h40, 7'h20, 4'd1, MOVE, 1'b1);
      @(negedge clk);
      n_chk++; if (miso_etc[5:2] !== 4'd15) $display("FAIL bad_err_sat: got %0h want f", miso_etc[5:2]); else n_pass++;
      n_chk++; if (link_ok !== 1'b1) $display("FAIL bad_link_ok: got %0h want 1", link_ok); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int c0;
      cmd_ready = 1'b0;
      send(8'h02, 7'h12, 4'd2, MOVE, 1'b0);
      n_chk++; if (cmd_x !== 8'h02) $display("FAIL bp_first: got %0h want 2", cmd_x); else n_pass++;
      send(8'h03, 7'h13, 4'd3, MOVE, 1'b0);
      send(8'h04, 7'h14, 4'd4, MOVE, 1'b0);
      n_chk++; if (cmd_x !== 8'h02 || cmd_valid !== 1'b1) $display("FAIL bp_hold: got x=%0h v=%0h want x=2 v=1", cmd_x, cmd_valid); else n_pass++;
      c0 = n_xfer;
      cmd_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (cmd_x !== 8'h04 || cmd_y !== 7'h14) $display("FAIL bp_skid: got x=%0h y=%0h want x=4 y=14", cmd_x, cmd_y); else n_pass++;
      n_chk++; if (cmd_valid !== 1'b1) $display("FAIL bp_skid_valid: got %0h want 1", cmd_valid); else n_pass++;
      @(negedge clk);
      n_chk++; if (cmd_valid !== 1'b0) $display("FAIL bp_drain: got %0h want 0", cmd_valid); else n_pass++;
      n_chk++; if (n_xfer - c0 !== 2) $display("FAIL bp_xfers: got %0d want 2", n_xfer - c0); else n_pass++;
   endtask

   task automatic test_duplicate;
      int c0;
      c0 = n_xfer;
      send(8'h05, 7'h05, 4'd5, MOVE, 1'b0);
      n_chk++; if (cmd_x !== 8'h05) $display("FAIL dup_x: got %0h want 5", cmd_x); else n_pass++;
      send(8'h05, 7'h05, 4'd5, MOVE, 1'b0);
      n_chk++; if (n_xfer - c0 !== 1) $display("FAIL dup_count: got %0d want 1", n_xfer - c0); else n_pass++;
      n_chk++; if (cmd_valid !== 1'b0) $display("FAIL dup_valid: got %0h want 0", cmd_valid); else n_pass++;
   endtask

   // Entered on the negedge right after the duplicate frame, which restarted the watchdog.
   task automatic test_timeout;
      cmd_ready = 1'b0;
      repeat (100) @(negedge clk);
      n_chk++; if (cmd_valid !== 1'b0 || link_ok !== 1'b1) $display("FAIL to_early: got v=%0h ok=%0h want v=0 ok=1", cmd_valid, link_ok); else n_pass++;
      @(negedge clk);
      n_chk++; if (cmd_valid !== 1'b1 || cmd_type !== HOME) $display("FAIL to_home: got v=%0h t=%0h want v=1 t=2", cmd_valid, cmd_type); else n_pass++;
      n_chk++; if (cmd_x !== 8'd128 || cmd_y !== 7'd64) $display("FAIL to_home_xy: got %0d,%0d want 128,64", cmd_x, cmd_y); else n_pass++;
      n_chk++; if (link_ok !== 1'b0) $display("FAIL to_link_ok: got %0h want 0", link_ok); else n_pass++;
      @(negedge clk);
      n_chk++; if (miso_etc[1:0] !== 2'b10) $display("FAIL to_issue_state: got %0h want 2", miso_etc[1:0]); else n_pass++;
      cmd_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (cmd_valid !== 1'b0) $display("FAIL to_home_xfer: got %0h want 0", cmd_valid); else n_pass++;
      @(negedge clk);
      n_chk++; if (miso_etc[1:0] !== 2'b11) $display("FAIL to_safe_state: got %0h want 3", miso_etc[1:0]); else n_pass++;
      send(8'h06, 7'h06, 4'd6, MOVE, 1'b0);
      n_chk++; if (link_ok !== 1'b1 || cmd_x !== 8'h06) $display("FAIL to_recover: got ok=%0h x=%0h want ok=1 x=6", link_ok, cmd_x); else n_pass++;
   endtask

   task automatic test_snapshot;
      cs_sync = 1'b0;
      det_valid = 1'b1; det_x = 10'd300; det_y = 9'd200;
      @(negedge clk);
      det_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++; if (enemy_xdata !== 10'd0 || enemy_ydata !== 9'd0) $display("FAIL snap_frozen: got %0d,%0d want 0,0", enemy_xdata, enemy_ydata); else n_pass++;
      cs_sync = 1'b1;
      @(negedge clk);
      n_chk++; if (enemy_xdata !== 10'd300 || enemy_ydata !== 9'd200) $display("FAIL snap_load: got %0d,%0d want 300,200", enemy_xdata, enemy_ydata); else n_pass++;
      @(negedge clk);
      n_chk++; if (miso_etc[8] !== 1'b1) $display("FAIL snap_fresh: got %0h want 1", miso_etc[8]); else n_pass++;
      send(8'h07, 7'h07, 4'd7, NOP, 1'b0);
      n_chk++; if (cmd_valid !== 1'b0) $display("FAIL snap_nop: got %0h want 0", cmd_valid); else n_pass++;
      @(negedge clk);
      n_chk++; if (miso_etc[8] !== 1'b0) $display("FAIL snap_fresh_clr: got %0h want 0", miso_etc[8]); else n_pass++;
      n_chk++; if (miso_etc[12:9] !== 4'd7) $display("FAIL snap_nop_seq: got %0h want 7", miso_etc[12:9]); else n_pass++;
   endtask

   task automatic test_reset_mid_issue;
      logic found;
      found = 1'b0;
      cmd_ready = 1'b0;
      for (int i = 0; i < 150 && !found; i++) begin
         @(negedge clk);
         if (cmd_valid) found = 1'b1;
      end
      n_chk++; if (found !== 1'b1 || cmd_type !== HOME) $display("FAIL ri_home: got found=%0h t=%0h want 1,2", found, cmd_type); else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_chk++; if (cmd_valid !== 1'b0) $display("FAIL ri_valid: got %0h want 0", cmd_valid); else n_pass++;
      n_chk++; if (cmd_type !== 2'b00 || link_ok !== 1'b0) $display("FAIL ri_clear: got t=%0h ok=%0h want 0,0", cmd_type, link_ok); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_chk++; if (miso_etc !== 13'h1E00) $display("FAIL ri_miso: got %0h want 1e00", miso_etc); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_move;
      test_bad_checksum;
      test_back_to_back;
      test_duplicate;
      test_timeout;
      test_snapshot;
      test_reset_mid_issue;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
